rob_multiport: RTL and testbench

- Parametrised successor to the current N-wide reorder buffer.
- Depth, dispatch width, completion width and retire width are independent parameters. Depth need not be a power of two.
- Entry payload and result are opaque bit vectors, so the same block serves integer and FP/LSQ-style ordering queues.
- Adds behaviour the current ROB lacks: explicit retire handshake, exception-gated retirement, partial squash to a given index, and full flush.
- Sits between dispatch (allocation), the CDB (completion) and the commit stage (retirement).

---
 rtl/rob_multiport.sv | 195 +++++++++++++++++++
 tb/tb_rob_multiport.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_multiport.sv
// Multi-port reorder buffer: N-wide dispatch, out-of-order completion and in-order retire
// over a circular buffer of arbitrary depth, with squash-to-index and full flush.
module rob_multiport #(
  parameter int unsigned DEPTH     = 32,
  parameter int unsigned DISP_W    = 3,
  parameter int unsigned CMPL_W    = 3,
  parameter int unsigned RET_W     = 3,
  parameter int unsigned PAYLOAD_W = 64,
  parameter int unsigned RESULT_W  = 32,
  parameter int unsigned IDX_W     = $clog2(DEPTH),
  parameter int unsigned CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [DISP_W-1:0]           disp_valid,
  input  logic [DISP_W*PAYLOAD_W-1:0] disp_payload,
  output logic [DISP_W*IDX_W-1:0]     disp_idx,
  output logic [CNT_W-1:0]            free_slots,
  input  logic [CMPL_W-1:0]           cmpl_valid,
  input  logic [CMPL_W*IDX_W-1:0]     cmpl_idx,
  input  logic [CMPL_W*RESULT_W-1:0]  cmpl_result,
  input  logic [CMPL_W-1:0]           cmpl_exc,
  output logic [RET_W-1:0]            head_valid,
  output logic [RET_W*PAYLOAD_W-1:0]  head_payload,
  output logic [RET_W*RESULT_W-1:0]   head_result,
  output logic [RET_W-1:0]            head_exc,
  input  logic [RET_W-1:0]            retire_en,
  input  logic                        squash_valid,
  input  logic [IDX_W-1:0]            squash_idx,
  input  logic                        flush,
  output logic [CNT_W-1:0]            count,
  output logic                        empty,
  output logic                        full
);

  // off never exceeds DEPTH, so one conditional subtract is enough.
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= DEPTH) s = s - DEPTH;
    return s[IDX_W-1:0];
  endfunction

  // Distance of idx from the oldest entry, 0 .. DEPTH-1.
  function automatic int unsigned age_of(input logic [IDX_W-1:0] oldest,
                                         input logic [IDX_W-1:0] idx);
    if (idx >= oldest) return 32'(idx) - 32'(oldest);
    return 32'(idx) + DEPTH - 32'(oldest);
  endfunction

  logic [IDX_W-1:0]     head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [DEPTH-1:0]     occ_q, occ_d, cmp_q, cmp_d, exc_q, exc_d;
  logic [PAYLOAD_W-1:0] payload_q [DEPTH];
  logic [RESULT_W-1:0]  result_q  [DEPTH];
  logic [DISP_W-1:0]    disp_ok;
  logic [CMPL_W-1:0]    cmpl_ok;

  always_comb begin
    int unsigned n_req, n_free, n_acc, n_ret, sq_age;
    logic [IDX_W-1:0] ci;
    logic [IDX_W-1:0] wi;

    n_req = 0;
    for (int k = 0; k < DISP_W; k++) n_req = n_req + 32'(disp_valid[k]);
    n_free = DEPTH - 32'(count_q);
    n_acc  = (n_req < n_free) ? n_req : n_free;
    n_ret  = 0;
    for (int k = 0; k < RET_W; k++) n_ret = n_ret + 32'(retire_en[k]);
    sq_age = age_of(head_q, squash_idx);

    for (int k = 0; k < DISP_W; k++) disp_ok[k] = !flush && !squash_valid && (k < n_acc);

    for (int k = 0; k < CMPL_W; k++) begin
      ci = cmpl_idx[k*IDX_W +: IDX_W];
      cmpl_ok[k] = 1'b0;
      if (!flush && cmpl_valid[k] && (32'(ci) < DEPTH)) begin
        cmpl_ok[k] = occ_q[ci] && !cmp_q[ci] && (!squash_valid || age_of(head_q, ci) <= sq_age);
      end
    end

    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    occ_d   = occ_q;
    cmp_d   = cmp_q;
    exc_d   = exc_q;
    ci      = '0;
    wi      = '0;

    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      occ_d   = '0;
      cmp_d   = '0;
      exc_d   = '0;
    end else begin
      for (int k = 0; k < RET_W; k++) begin
        if (k < n_ret) begin
          wi = wrap_add(head_q, k);
          occ_d[wi] = 1'b0;
          cmp_d[wi] = 1'b0;
          exc_d[wi] = 1'b0;
        end
      end
      head_d = wrap_add(head_q, n_ret);

      // Ascending lane order lets the highest lane win on duplicate indices.
      for (int k = 0; k < CMPL_W; k++) begin
        if (cmpl_ok[k]) begin
          ci = cmpl_idx[k*IDX_W +: IDX_W];
          cmp_d[ci] = 1'b1;
          exc_d[ci] = cmpl_exc[k];
        end
      end

      if (squash_valid) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (age_of(head_q, IDX_W'(i)) > sq_age) begin
            occ_d[i] = 1'b0;
            cmp_d[i] = 1'b0;
            exc_d[i] = 1'b0;
          end
        end
        tail_d  = wrap_add(squash_idx, 1);
        count_d = CNT_W'(sq_age + 1 - n_ret);
      end else begin
        for (int k = 0; k < DISP_W; k++) begin
          if (disp_ok[k]) begin
            wi = wrap_add(tail_q, k);
            occ_d[wi] = 1'b1;
            cmp_d[wi] = 1'b0;
            exc_d[wi] = 1'b0;
          end
        end
        tail_d  = wrap_add(tail_q, n_acc);
        count_d = CNT_W'(32'(count_q) + n_acc - n_ret);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      occ_q   <= '0;
      cmp_q   <= '0;
      exc_q   <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      occ_q   <= occ_d;
      cmp_q   <= cmp_d;
      exc_q   <= exc_d;
    end
  end

  // Data arrays are qualified by the occupancy bits, so they carry no reset.
  always_ff @(posedge clock) begin
    for (int k = 0; k < DISP_W; k++) begin
      if (disp_ok[k]) payload_q[wrap_add(tail_q, k)] <= disp_payload[k*PAYLOAD_W +: PAYLOAD_W];
    end
    for (int k = 0; k < CMPL_W; k++) begin
      if (cmpl_ok[k]) result_q[cmpl_idx[k*IDX_W +: IDX_W]] <= cmpl_result[k*RESULT_W +: RESULT_W];
    end
  end

  always_comb begin
    logic             chain;
    logic             hv;
    logic [IDX_W-1:0] ri;
    chain = 1'b1;
    for (int k = 0; k < RET_W; k++) begin
      ri = wrap_add(head_q, k);
      hv = chain && occ_q[ri] && cmp_q[ri];
      head_valid[k] = hv;
      head_exc[k]   = exc_q[ri];
      head_payload[k*PAYLOAD_W +: PAYLOAD_W] = payload_q[ri];
      head_result[k*RESULT_W +: RESULT_W]    = result_q[ri];
      // An excepting entry ends the retire group so commit traps on it alone.
      chain = hv && !exc_q[ri];
    end
    for (int k = 0; k < DISP_W; k++) disp_idx[k*IDX_W +: IDX_W] = wrap_add(tail_q, k);
  end

  assign count      = count_q;
  assign free_slots = CNT_W'(DEPTH) - count_q;
  assign empty      = (count_q == '0);
  assign full       = (count_q == CNT_W'(DEPTH));

endmodule

// File: tb/tb_rob_multiport.sv
// Scoreboard bench for rob_multiport: a 32-entry 3-wide instance driven through directed
// scenarios and a 12-entry 4-wide instance driven with random traffic across wrap.
module tb_rob_multiport;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic [2:0]   m_dv, m_cv, m_ce, m_hv, m_he, m_ret;
  logic [191:0] m_dp, m_hp;
  logic [14:0]  m_didx, m_ci;
  logic [95:0]  m_cr, m_hr;
  logic [5:0]   m_free, m_cnt;
  logic [4:0]   m_sqi;
  logic         m_sqv, m_flush, m_empty, m_full;

  logic [3:0]   s_dv, s_cv, s_ce, s_hv, s_he, s_ret, s_free, s_cnt, s_sqi;
  logic [63:0]  s_dp, s_cr, s_hp, s_hr;
  logic [15:0]  s_didx, s_ci;
  logic         s_sqv, s_flush, s_empty, s_full;

  rob_multiport u_main (
    .clock(clock), .reset(reset),
    .disp_valid(m_dv), .disp_payload(m_dp), .disp_idx(m_didx), .free_slots(m_free),
    .cmpl_valid(m_cv), .cmpl_idx(m_ci), .cmpl_result(m_cr), .cmpl_exc(m_ce),
    .head_valid(m_hv), .head_payload(m_hp), .head_result(m_hr), .head_exc(m_he),
    .retire_en(m_ret), .squash_valid(m_sqv), .squash_idx(m_sqi), .flush(m_flush),
    .count(m_cnt), .empty(m_empty), .full(m_full)
  );

  rob_multiport #(
    .DEPTH(12), .DISP_W(4), .CMPL_W(4), .RET_W(4), .PAYLOAD_W(16), .RESULT_W(16)
  ) u_small (
    .clock(clock), .reset(reset),
    .disp_valid(s_dv), .disp_payload(s_dp), .disp_idx(s_didx), .free_slots(s_free),
    .cmpl_valid(s_cv), .cmpl_idx(s_ci), .cmpl_result(s_cr), .cmpl_exc(s_ce),
    .head_valid(s_hv), .head_payload(s_hp), .head_result(s_hr), .head_exc(s_he),
    .retire_en(s_ret), .squash_valid(s_sqv), .squash_idx(s_sqi), .flush(s_flush),
    .count(s_cnt), .empty(s_empty), .full(s_full)
  );

  typedef struct {
    logic [3:0]  idx;
    logic [15:0] pay;
    logic [15:0] res;
    bit          done;
  } ent_t;

  int n_total = 0;
  int n_bad   = 0;

  logic [63:0] m_sb[$];
  logic [31:0] m_res[32];
  int          m_head, m_tail, seq;
  ent_t        sb2[$];
  int          s_tail;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clock);
    @(negedge clock);
    m_dv = '0; m_cv = '0; m_ce = '0; m_ret = '0; m_sqv = 1'b0; m_flush = 1'b0;
    s_dv = '0; s_cv = '0; s_ce = '0; s_ret = '0; s_sqv = 1'b0; s_flush = 1'b0;
  endtask

  task automatic check_main(input logic [2:0] hv);
    check("m_count", 64'(m_cnt), 64'(m_sb.size()));
    check("m_free", 64'(m_free), 64'(32 - m_sb.size()));
    check("m_empty", 64'(m_empty), 64'(m_sb.size() == 0));
    check("m_full", 64'(m_full), 64'(m_sb.size() == 32));
    check("m_tail", 64'(m_didx[4:0]), 64'(m_tail));
    check("m_hv", 64'(m_hv), 64'(hv));
  endtask

  // Requests beyond the free slots are dropped by the DUT, so only accepted lanes are pushed.
  task automatic dispatch_main(input int n);
    int free_n, acc;
    logic [63:0] p;
    free_n = 32 - m_sb.size();
    acc = (n < free_n) ? n : free_n;
    for (int k = 0; k < n; k++) begin
      p = {32'hA5A5_0000, 32'(seq + k)};
      m_dv[k] = 1'b1;
      m_dp[k*64 +: 64] = p;
      if (k < acc) m_sb.push_back(p);
    end
    seq = seq + n;
    m_tail = (m_tail + acc) % 32;
  endtask

  task automatic complete_main(input int lane, input int idx, input bit exc, input bit applies);
    logic [31:0] r;
    r = {16'hC0DE, 8'(lane), 8'(idx)};
    m_cv[lane] = 1'b1;
    m_ci[lane*5 +: 5] = 5'(idx);
    m_cr[lane*32 +: 32] = r;
    m_ce[lane] = exc;
    if (applies) m_res[idx] = r;
  endtask

  task automatic retire_main(input int r);
    logic [63:0] p;
    for (int k = 0; k < r; k++) begin
      if (m_sb.size() == 0) begin
        check("m_sb_underflow", 64'(1), 64'(0));
      end else begin
        p = m_sb.pop_front();
        check("m_ret_pay", m_hp[k*64 +: 64], p);
        check("m_ret_res", 64'(m_hr[k*32 +: 32]), 64'(m_res[(m_head + k) % 32]));
      end
      m_ret[k] = 1'b1;
    end
    m_head = (m_head + r) % 32;
  endtask

  initial begin
    m_dv = '0; m_dp = '0; m_cv = '0; m_ci = '0; m_cr = '0; m_ce = '0; m_ret = '0;
    m_sqv = 1'b0; m_sqi = '0; m_flush = 1'b0;
    s_dv = '0; s_dp = '0; s_cv = '0; s_ci = '0; s_cr = '0; s_ce = '0; s_ret = '0;
    s_sqv = 1'b0; s_sqi = '0; s_flush = 1'b0;
    m_head = 0; m_tail = 0; seq = 0; s_tail = 0;
    for (int i = 0; i < 32; i++) m_res[i] = '0;

    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;

    check_main(3'b000);
    for (int k = 0; k < 3; k++) check("m_didx_rst", 64'(m_didx[k*5 +: 5]), 64'(k));

    // Fill: 33 requests, the last one dropped, tail wraps to 0.
    for (int c = 0; c < 11; c++) begin
      check("m_fill_tail", 64'(m_didx[4:0]), 64'(m_tail));
      dispatch_main(3);
      cycle();
    end
    check_main(3'b000);

    for (int l = 0; l < 3; l++) complete_main(l, l, 1'b0, 1'b1);
    cycle();
    check_main(3'b111);
    // Full: same-cycle dispatch is dropped, freed slots show up next cycle.
    dispatch_main(3);
    retire_main(3);
    cycle();
    check_main(3'b000);

    complete_main(0, 4, 1'b1, 1'b1);
    complete_main(1, 3, 1'b0, 1'b1);
    complete_main(2, 5, 1'b0, 1'b1);
    cycle();
    check_main(3'b011);
    check("m_hexc", 64'(m_he[1:0]), 64'(2'b10));
    retire_main(2);
    cycle();
    check_main(3'b001);
    check("m_hexc5", 64'(m_he[0]), 64'(0));

    // Flush overrides a concurrent dispatch and retire.
    m_flush = 1'b1;
    m_dv = 3'b111;
    m_ret = 3'b001;
    cycle();
    m_sb.delete();
    m_head = 0;
    m_tail = 0;
    check_main(3'b000);

    // Move head to 30, then hold 20 entries (30..17).
    for (int c = 0; c < 10; c++) begin dispatch_main(3); cycle(); end
    for (int c = 0; c < 10; c++) begin
      for (int l = 0; l < 3; l++) complete_main(l, 3 * c + l, 1'b0, 1'b1);
      cycle();
    end
    for (int c = 0; c < 10; c++) begin
      check("m_drain_hv", 64'(m_hv), 64'(3'b111));
      retire_main(3);
      cycle();
    end
    check_main(3'b000);
    for (int c = 0; c < 7; c++) begin dispatch_main((c < 6) ? 3 : 2); cycle(); end
    complete_main(0, 30, 1'b0, 1'b1);
    cycle();
    check_main(3'b001);

    // Squash to idx 2 with one retire; dispatch and the completion to idx 7 are ignored.
    m_sqv = 1'b1;
    m_sqi = 5'd2;
    m_dv = 3'b111;
    retire_main(1);
    complete_main(0, 7, 1'b0, 1'b0);
    cycle();
    while (m_sb.size() > 4) void'(m_sb.pop_back());
    m_tail = 3;
    check_main(3'b000);

    dispatch_main(3); cycle();
    dispatch_main(3); cycle();
    complete_main(0, 31, 1'b0, 1'b1); complete_main(1, 0, 1'b0, 1'b1);
    complete_main(2, 1, 1'b0, 1'b1); cycle();
    complete_main(0, 2, 1'b0, 1'b1); complete_main(1, 3, 1'b0, 1'b1);
    complete_main(2, 4, 1'b0, 1'b1); cycle();
    complete_main(0, 5, 1'b0, 1'b1); complete_main(1, 6, 1'b0, 1'b1); cycle();
    check_main(3'b111); retire_main(3); cycle();
    check_main(3'b111); retire_main(3); cycle();
    check_main(3'b011); retire_main(2); cycle();
    check_main(3'b000);

    // Reset in the middle of operation discards everything.
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    m_sb.delete();
    m_head = 0;
    m_tail = 0;
    check_main(3'b000);

    // Small instance: random dispatch/complete/retire across wrap, flush at cycle 30.
    for (int cyc = 0; cyc < 50; cyc++) begin
      int lead, nret, ncm, nd, c, sz;
      ent_t e;
      sz = sb2.size();
      check("s_count", 64'(s_cnt), 64'(sz));
      check("s_free", 64'(s_free), 64'(12 - sz));
      check("s_full", 64'(s_full), 64'(sz == 12));
      check("s_empty", 64'(s_empty), 64'(sz == 0));
      for (int k = 0; k < 4; k++) check("s_didx", 64'(s_didx[k*4 +: 4]), 64'((s_tail + k) % 12));
      lead = 0;
      while (lead < 4 && lead < sz && sb2[lead].done) lead++;
      check("s_hv", 64'(s_hv), 64'((1 << lead) - 1));
      if (cyc == 30) begin
        s_flush = 1'b1;
        s_dv = 4'hF;
        s_ret = 4'((1 << lead) - 1);
        sb2.delete();
        s_tail = 0;
      end else begin
        nret = int'($urandom_range(lead, 0));
        for (int k = 0; k < nret; k++) begin
          e = sb2.pop_front();
          check("s_ret_pay", 64'(s_hp[k*16 +: 16]), 64'(e.pay));
          check("s_ret_res", 64'(s_hr[k*16 +: 16]), 64'(e.res));
          s_ret[k] = 1'b1;
        end
        ncm = int'($urandom_range(4, 0));
        c = 0;
        for (int i = 0; i < sb2.size() && c < ncm; i++) begin
          if (!sb2[i].done) begin
            e = sb2[i];
            e.res = 16'($urandom);
            e.done = 1'b1;
            sb2[i] = e;
            s_cv[c] = 1'b1;
            s_ci[c*4 +: 4] = e.idx;
            s_cr[c*16 +: 16] = e.res;
            c++;
          end
        end
        nd = int'($urandom_range(4, 0));
        if (nd > 12 - sz) nd = 12 - sz;
        for (int k = 0; k < nd; k++) begin
          e.idx = 4'((s_tail + k) % 12);
          e.pay = 16'($urandom);
          e.res = '0;
          e.done = 1'b0;
          s_dv[k] = 1'b1;
          s_dp[k*16 +: 16] = e.pay;
          sb2.push_back(e);
        end
        s_tail = (s_tail + nd) % 12;
      end
      cycle();
    end
    check("s_end_count", 64'(s_cnt), 64'(sb2.size()));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
